// File: rtl/mem_access_unit.sv
// Load/store unit: serialises CPU requests onto a data memory with a 1-cycle registered read.
// Build option: define LSU_SUBWORD_EN for byte/half accesses (read-modify-write stores, sign extension).
module mem_access_unit #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGNED,
  input  logic [31:0] REQ_ADR,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        DM_WE,
  output logic [31:0] DM_ADR,
  output logic [31:0] DM_WDATA,
  input  logic [31:0] DM_RDATA
);

  localparam logic [31:0] DMEM_WORDS_W = 32'(DMEM_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
`ifdef LSU_SUBWORD_EN
    RMW_ISSUE,
    RMW_WAIT,
`endif
    WR,
    RESP
  } state_t;

  state_t      state_q;
  logic        err_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        req_err;
  logic        adr_phase;

`ifdef LSU_SUBWORD_EN
  logic [1:0]  size_q;
  logic        signed_q;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      2'b00:   load_lane = {{24{sgn & b[7]}}, b};
      2'b01:   load_lane = {{16{sgn & h[15]}}, h};
      default: load_lane = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [15:0] d);
    merge_lane = w;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    merge_lane[31:24] = d[7:0];
        2'd1:    merge_lane[23:16] = d[7:0];
        2'd2:    merge_lane[15:8]  = d[7:0];
        default: merge_lane[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      merge_lane[15:0] = d;
    end else begin
      merge_lane[31:16] = d;
    end
  endfunction
`else
  // Word-only build: sign control and the byte offset have no effect.
  logic unused_subword;
  assign unused_subword = ^{REQ_SIGNED, adr_q[1:0]};
`endif

  always_comb begin
    req_err = ({2'b00, REQ_ADR[31:2]} >= DMEM_WORDS_W);
`ifdef LSU_SUBWORD_EN
    case (REQ_SIZE)
      2'b00:   req_err = req_err;
      2'b01:   req_err = req_err | REQ_ADR[0];
      2'b10:   req_err = req_err | (REQ_ADR[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
`else
    req_err = req_err | (REQ_SIZE != 2'b10) | (REQ_ADR[1:0] != 2'b00);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      adr_q   <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef LSU_SUBWORD_EN
      size_q   <= 2'b00;
      signed_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            adr_q   <= REQ_ADR;
            wdata_q <= REQ_WDATA;
            err_q   <= req_err;
`ifdef LSU_SUBWORD_EN
            size_q   <= REQ_SIZE;
            signed_q <= REQ_SIGNED;
`endif
            if (req_err)              state_q <= RESP;
            else if (!REQ_WE)         state_q <= RD_ISSUE;
`ifdef LSU_SUBWORD_EN
            else if (REQ_SIZE != 2'b10) state_q <= RMW_ISSUE;
`endif
            else                      state_q <= WR;
          end
        end
        RD_ISSUE: state_q <= RD_WAIT;
        RD_WAIT: begin
`ifdef LSU_SUBWORD_EN
          rdata_q <= load_lane(DM_RDATA, size_q, adr_q[1:0], signed_q);
`else
          rdata_q <= DM_RDATA;
`endif
          state_q <= RESP;
        end
`ifdef LSU_SUBWORD_EN
        RMW_ISSUE: state_q <= RMW_WAIT;
        RMW_WAIT: begin
          // wdata_q still holds the right-justified store data until it is merged here.
          wdata_q <= merge_lane(DM_RDATA, size_q, adr_q[1:0], wdata_q[15:0]);
          state_q <= WR;
        end
`endif
        WR:      state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    adr_phase = (state_q == RD_ISSUE) || (state_q == WR);
`ifdef LSU_SUBWORD_EN
    if (state_q == RMW_ISSUE) adr_phase = 1'b1;
`endif
  end

  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == RESP);
  assign ERR      = (state_q == RESP) && err_q;
  assign RDATA    = rdata_q;
  // Gated with RST so a reset landing in WR never commits a partial store.
  assign DM_WE    = (state_q == WR) && !RST;
  assign DM_ADR   = adr_phase ? {adr_q[31:2], 2'b00} : 32'h0;
  assign DM_WDATA = (state_q == WR) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model, per-cycle output
// compare, directed literal cases and randomized traffic. Follows LSU_SUBWORD_EN like the RTL.
module tb_mem_access_unit;
  localparam int DW   = 1024;
  localparam int NPRE = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic        req_signed = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_adr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        busy, done, err, dm_we;
  logic [31:0] rdata, dm_adr, dm_wdata, dm_rdata;

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic chk_en = 1'b0;

  mem_access_unit #(.DMEM_WORDS(DW)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_WE(req_we), .REQ_SIZE(req_size),
    .REQ_SIGNED(req_signed), .REQ_ADR(req_adr), .REQ_WDATA(req_wdata),
    .BUSY(busy), .DONE(done), .ERR(err), .RDATA(rdata),
    .DM_WE(dm_we), .DM_ADR(dm_adr), .DM_WDATA(dm_wdata), .DM_RDATA(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory driven by the DUT, with a preload path used during reset.
  logic [31:0] dmem [0:DW-1];
  logic        pre_we = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_val = 32'h0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (pre_we) dmem[pre_idx] <= pre_val;
    else if (dm_we) begin
      dmem[dm_adr[11:2]] <= dm_wdata;
      we_cnt <= we_cnt + 1;
    end
    dm_rdata <= dmem[dm_adr[11:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] a);
    if ((a >> 2) >= 32'(DW)) return 1'b1;
`ifdef LSU_SUBWORD_EN
    if (sz == 2'b11) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
`else
    return (sz != 2'b10) || (a % 4 != 0);
`endif
  endfunction

  function automatic int model_lat(input bit bad, input logic we, input logic [1:0] sz);
    if (bad) return 1;
    if (!we) return 3;
    if (sz == 2'b10) return 2;
    return 4;
  endfunction

  // Load: the extended lane value. Store: the full memory word after the store.
  function automatic logic [31:0] model_result(input logic we, input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a, input logic [31:0] wd,
                                               input logic [31:0] old);
    int nbytes, shift;
    logic [31:0] lane_mask, v;
    if (sz == 2'b11) return 32'h0;
    nbytes = 1 << sz;
    if (nbytes == 4) return we ? wd : old;
    shift = 8 * (4 - nbytes - int'(a % 4));
    lane_mask = (32'h1 << (8 * nbytes)) - 32'h1;
    if (we) return (old & ~(lane_mask << shift)) | ((wd & lane_mask) << shift);
    v = (old >> shift) & lane_mask;
    if (sg && v[8 * nbytes - 1]) v = v | ~lane_mask;
    return v;
  endfunction

  logic [31:0] ref_mem [0:DW-1];
  int          m_phase = 0;
  int          m_lat = 1;
  logic        m_err = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_adr = 32'h0;
  logic [31:0] m_res = 32'h0;
  logic [31:0] m_rdata = 32'h0;

  always @(posedge clk) begin
    if (pre_we) ref_mem[pre_idx] <= pre_val;
    if (rst) begin
      m_phase <= 0;
      m_rdata <= 32'h0;
    end else if (m_phase == 0) begin
      if (req) begin
        m_err   <= model_bad(req_size, req_adr);
        m_lat   <= model_lat(model_bad(req_size, req_adr), req_we, req_size);
        m_we    <= req_we;
        m_adr   <= req_adr;
        m_res   <= model_result(req_we, req_size, req_signed, req_adr, req_wdata,
                                ref_mem[req_adr[11:2]]);
        m_phase <= 1;
      end
    end else begin
      if (!m_err && m_phase == m_lat - 1) begin
        if (m_we) ref_mem[m_adr[11:2]] <= m_res;
        else m_rdata <= m_res;
      end
      m_phase <= (m_phase == m_lat) ? 0 : m_phase + 1;
    end
  end

  logic        m_act, m_wr;
  logic [31:0] m_dm_adr;
  assign m_act    = (m_phase != 0);
  assign m_wr     = m_act && !m_err && m_we && (m_phase == m_lat - 1);
  assign m_dm_adr = (m_act && !m_err && (m_phase == 1 || m_wr)) ? {m_adr[31:2], 2'b00} : 32'h0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_act);
      chk("done", done, m_act && m_phase == m_lat);
      chk("err", err, m_act && m_phase == m_lat && m_err);
      chk("rdata", rdata, m_rdata);
      chk("dm_we", dm_we, m_wr && !rst);
      chk("dm_adr", dm_adr, m_dm_adr);
      chk("dm_wdata", dm_wdata, m_wr ? m_res : 32'h0);
    end
  end

  // ---------------- driver ----------------
  // Called and returning at posedge+1 with the DUT idle; cyc counts edges from acceptance.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int rst_at,
                        output int cyc, output logic e, output logic [31:0] rd);
    req = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_adr = a; req_wdata = wd;
    e = 1'b0; rd = 32'h0; cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == rst_at) begin
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      if (done) begin
        e = err; rd = rdata; req = 1'b0;
        @(posedge clk); #1;
        break;
      end
      if (cyc >= 8) begin
        checks++; errors++;
        $display("FAIL timeout: no done within %0d cycles, required at most 4", cyc);
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      // Junk on the request port while busy must be ignored.
      req = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_adr = $urandom; req_wdata = $urandom;
    end
    txn++;
    $display("txn %0d we=%0d size=%0d sgn=%0d adr=%h wdata=%h rst_at=%0d cycles=%0d err=%0d rdata=%h",
             txn, we, sz, sg, a, wd, rst_at, cyc, e, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, wc, rs;
    logic e;
    logic [31:0] rd, a;
    logic [1:0] sz;

    for (int i = 0; i < NPRE; i++) begin
      @(posedge clk); #1;
      pre_we = 1'b1; pre_idx = i; pre_val = $urandom;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_dm_we", dm_we, 1'b0);
    chk("reset_dm_adr", dm_adr, 32'h0);
    chk_en = 1'b1;
    rst = 1'b0;

    wc = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 0, cyc, e, rd);
    chk("st_w_latency", cyc, 2);
    chk("st_w_err", e, 1'b0);
    chk("st_w_we_cycles", we_cnt - wc, 1);
    chk("st_w_mem", dmem[4], 32'h12345678);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, cyc, e, rd);
    chk("ld_w_latency", cyc, 3);
    chk("ld_w_rdata", rd, 32'h12345678);

    do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, cyc, e, rd);
    chk("misalign_latency", cyc, 1);
    chk("misalign_err", e, 1'b1);
    chk("misalign_rdata", rd, 32'h12345678);

    do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0, cyc, e, rd);
    chk("range_latency", cyc, 1);
    chk("range_err", e, 1'b1);
    chk("range_rdata", rd, 32'h12345678);

`ifdef LSU_SUBWORD_EN
    wc = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 0, cyc, e, rd);
    chk("st_b_latency", cyc, 4);
    chk("st_b_we_cycles", we_cnt - wc, 1);
    chk("st_b_mem", dmem[4], 32'h12AB5678);
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, cyc, e, rd);
    chk("ld_b_signed", rd, 32'hFFFFFFAB);
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, cyc, e, rd);
    chk("ld_b_unsigned", rd, 32'h000000AB);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h80007FFF, 0, cyc, e, rd);
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 0, cyc, e, rd);
    chk("ld_h_signed_0", rd, 32'hFFFF8000);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, cyc, e, rd);
    chk("ld_h_signed_2", rd, 32'h00007FFF);
    // Reset lands while the byte store sits in WR (third edge after acceptance).
    wc = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000CD, 3, cyc, e, rd);
    chk("rst_wr_mem", dmem[4], 32'h12AB5678);
    chk("rst_wr_we_cycles", we_cnt - wc, 0);
    chk("rst_wr_busy", busy, 1'b0);
    chk("rst_wr_rdata", rdata, 32'h0);
`else
    wc = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000AB, 0, cyc, e, rd);
    chk("st_b_err", e, 1'b1);
    chk("st_b_latency", cyc, 1);
    chk("st_b_we_cycles", we_cnt - wc, 0);
    chk("st_b_mem", dmem[4], 32'h12345678);
    // Reset lands while the word store sits in WR (first edge after acceptance).
    wc = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1, cyc, e, rd);
    chk("rst_wr_mem", dmem[4], 32'h12345678);
    chk("rst_wr_we_cycles", we_cnt - wc, 0);
    chk("rst_wr_busy", busy, 1'b0);
    chk("rst_wr_rdata", rdata, 32'h0);
`endif

    for (int t = 0; t < 250; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, NPRE - 1)) << 2;
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (sz == 2'b10) ? 2'b00 : ((sz == 2'b01) ? {1'($urandom), 1'b0} : 2'($urandom));
      else
        a[1:0] = 2'($urandom);
      if ($urandom_range(0, 19) == 0)
        a = a | (($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h8000_0000);
      rs = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, rs, cyc, e, rd);
      if ((a >> 2) < 32'(DW)) chk("rand_mem_word", dmem[a[11:2]], ref_mem[a[11:2]]);
    end

    for (int i = 0; i < NPRE; i++) chk("final_mem", dmem[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 1024: number of 32-bit words in the attached data memory; word index >= DMEM_WORDS is out of range.
REQ-002 SHALL have port CLK  in  1  clock, all state updates on posedge.
REQ-003 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port REQ  in  1  CPU access request, sampled only in IDLE.
REQ-005 SHALL have port REQ_WE  in  1  1 = store, 0 = load.
REQ-006 SHALL have port REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port REQ_SIGNED  in  1  sign-extend sub-word loads.
REQ-008 SHALL have port REQ_ADR  in  32  byte address.
REQ-009 SHALL have port REQ_WDATA  in  32  store data, right-justified.
REQ-010 SHALL have port BUSY  out  1  high in every state except IDLE.
REQ-011 SHALL have port DONE  out  1  one-cycle completion pulse.
REQ-012 SHALL have port ERR  out  1  high with DONE when the request was rejected.
REQ-013 SHALL have port RDATA  out  32  registered load result.
REQ-014 SHALL have ports DM_WE out 1, DM_ADR out 32, DM_WDATA out 32, DM_RDATA in 32, which drive a data memory with a registered 1-cycle read (DM_RDATA valid the cycle after the address is presented with DM_WE=0).

Function
REQ-015 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, RMW_ISSUE, RMW_WAIT, WR, RESP.
REQ-016 SHALL, in IDLE with REQ=1, latch all REQ_* inputs and go to RESP with error flag set if misaligned (half: ADR[0]=1; word: ADR[1:0]!=0), out of range (ADR[31:2] >= DMEM_WORDS) or REQ_SIZE=11.
REQ-017 SHALL otherwise go to: load -> RD_ISSUE; word store -> WR; sub-word store -> RMW_ISSUE.
REQ-018 SHALL sequence RD_ISSUE->RD_WAIT->RESP, RMW_ISSUE->RMW_WAIT->WR->RESP, WR->RESP, RESP->IDLE; REQ SHALL be ignored outside IDLE.
REQ-019 SHALL drive DM_ADR = {ADR[31:2],2'b00} in RD_ISSUE, RMW_ISSUE and WR, and 0 elsewhere.
REQ-020 SHALL assert DM_WE only in WR and only while RST=0; DM_WDATA SHALL be the store word in WR, 0 elsewhere.
REQ-021 SHALL use big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-022 SHALL, in RD_WAIT, extract the addressed lane from DM_RDATA, zero- or sign-extend per REQ_SIGNED, and register it into RDATA at the end of that cycle.
REQ-023 SHALL, in RMW_WAIT, register DM_RDATA with the addressed lane replaced by REQ_WDATA[7:0] or [15:0] as the WR data.
REQ-024 SHALL assert DONE=1 only in RESP, with ERR=1 only for rejected requests.
REQ-025 SHALL give latency from the accepting edge to DONE of: error 1 cycle, word store 2, load 3, sub-word store 4.
REQ-026 SHALL leave RDATA unchanged by stores and rejected requests.

Reset
REQ-027 SHALL, on RST=1 at a clock edge, enter IDLE and clear RDATA, DONE, ERR, BUSY and the latched request, regardless of current state.
REQ-028 SHALL perform no memory write in any cycle with RST=1, including a reset arriving in WR mid-RMW.

Configuration
REQ-029 SHALL support sub-word accesses (REQ_SIZE 00/01, RMW path, sign extension) only when LSU_SUBWORD_EN is defined.
REQ-030 SHALL, without LSU_SUBWORD_EN, reject every REQ_SIZE other than 10 as an error, ignore REQ_SIGNED, and omit the RMW_ISSUE and RMW_WAIT states.

Verification
REQ-031 SHALL verify: word store 0x12345678 @0x10, then word load @0x10 -> DM_WE high exactly 1 cycle, DONE 2 cycles after the store is accepted, RDATA=0x12345678 3 cycles after the load is accepted.
REQ-032 SHALL verify: byte store 0xAB @0x11 onto 0x12345678 -> memory word 0x12AB5678; signed byte load @0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-033 SHALL verify: word 0x80007FFF at 0x20; signed half loads @0x20 -> 0xFFFF8000 and @0x22 -> 0x00007FFF.
REQ-034 SHALL verify: word load @0x13, and word load @0x1000 with DMEM_WORDS=1024 -> DONE=ERR=1 one cycle after acceptance, DM_ADR stays 0, RDATA unchanged.
REQ-035 SHALL verify: RST asserted during WR of a byte store -> DM_WE=0 that cycle, memory word unchanged, BUSY=0 and RDATA=0 after the edge.
REQ-036 SHALL verify: without LSU_SUBWORD_EN, byte store @0x10 -> ERR=1, no DM write.
